fir_xifu_scoreboard: RTL

//  In-flight instruction scoreboard and issue gate for the FIR XIFU, instantiated inside fir_xifu_ctrl.
//  - Tracks every offloaded instruction from XIF issue through commit/kill to WB retire.
//  - Stalls issue on XIFU-regfile RAW/WAW hazards, a full table or a duplicate id.
//  - Tells EX whether its current instruction is committed, so that side effects (mem req, regfile write) are allowed.

---
 rtl/fir_xifu_pkg.sv | 22 ++
 rtl/fir_xifu_sb_entry.sv | 98 +++++++++
 rtl/fir_xifu_scoreboard.sv | 117 +++++++++++
 3 files changed

// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU: scoreboard entry state and record layout.
package fir_xifu_pkg;

    localparam int SB_NB_ENTRIES = 4;
    localparam int SB_NB_REGS    = 4;
    localparam int SB_ID_WIDTH   = 4;
    localparam int SB_REG_W      = $clog2(SB_NB_REGS);

    typedef enum logic [1:0] {
        SB_FREE      = 2'd0,
        SB_ISSUED    = 2'd1,
        SB_COMMITTED = 2'd2
    } sb_state_e;

    typedef struct packed {
        sb_state_e               state;
        logic [SB_ID_WIDTH-1:0]  id;
        logic [SB_REG_W-1:0]     rd;
        logic                    we;
    } sb_entry_t;

endpackage

// File: rtl/fir_xifu_sb_entry.sv
// One scoreboard slot: tracks a single offloaded instruction from issue to retire.
//
//  state        | meaning
//  SB_FREE      | slot empty, may be allocated
//  SB_ISSUED    | instruction accepted, waiting for commit or kill
//  SB_COMMITTED | commit seen, EX side effects allowed until WB retires it
module fir_xifu_sb_entry
    import fir_xifu_pkg::*;
#(
    parameter int ID_WIDTH = SB_ID_WIDTH,
    parameter int REG_W    = SB_REG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                alloc,
    input  logic [ID_WIDTH-1:0] alloc_id,
    input  logic [REG_W-1:0]    alloc_rd,
    input  logic                alloc_we,
    input  logic                commit_valid,
    input  logic [ID_WIDTH-1:0] commit_id,
    input  logic                commit_kill,
    input  logic                retire_valid,
    input  logic [ID_WIDTH-1:0] retire_id,
    input  logic [ID_WIDTH-1:0] lookup_id,
    input  logic [ID_WIDTH-1:0] ex_id,
    output logic                busy,
    output logic [REG_W-1:0]    rd,
    output logic                we,
    output logic                lookup_hit,
    output logic                ex_hit,
    output logic                kill_hit,
    output logic                retire_hit
);

    sb_state_e           state_q, state_d;
    logic [ID_WIDTH-1:0] id_q;
    logic [REG_W-1:0]    rd_q;
    logic                we_q;
    logic                commit_hit;
    logic                retire_match;
    logic                alloc_commit;

    assign commit_hit   = commit_valid && (commit_id == id_q);
    assign retire_match = retire_valid && (retire_id == id_q);
    assign alloc_commit = commit_valid && (commit_id == alloc_id);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SB_FREE;
            id_q    <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (alloc) begin
                id_q <= alloc_id;
                rd_q <= alloc_rd;
                we_q <= alloc_we;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = SB_FREE;
        end else begin
            unique case (state_q)
                SB_FREE: begin
                    // a commit arriving with its own issue skips the ISSUED step
                    if (alloc) begin
                        if (alloc_commit) state_d = commit_kill ? SB_FREE : SB_COMMITTED;
                        else              state_d = SB_ISSUED;
                    end
                end
                SB_ISSUED: begin
                    if (commit_hit) state_d = commit_kill ? SB_FREE : SB_COMMITTED;
                end
                SB_COMMITTED: begin
                    if (retire_match) state_d = SB_FREE;
                end
                default: state_d = SB_FREE;
            endcase
        end
    end

    always_comb begin
        busy       = (state_q != SB_FREE);
        rd         = rd_q;
        we         = busy && we_q;
        lookup_hit = busy && (id_q == lookup_id);
        ex_hit     = (state_q == SB_COMMITTED) && (id_q == ex_id);
        kill_hit   = (state_q == SB_ISSUED) && commit_hit && commit_kill;
        retire_hit = (state_q == SB_COMMITTED) && retire_match;
    end

endmodule

// File: rtl/fir_xifu_scoreboard.sv
// In-flight instruction scoreboard and issue gate for the FIR XIFU.
// Holds the slot array, lowest-free allocator, hazard/dup reduction and occupancy counter.
module fir_xifu_scoreboard
    import fir_xifu_pkg::*;
#(
    parameter int NB_REGS    = SB_NB_REGS,
    parameter int NB_ENTRIES = SB_NB_ENTRIES,
    parameter int ID_WIDTH   = SB_ID_WIDTH,
    localparam int REG_W     = $clog2(NB_REGS),
    localparam int CNT_W     = $clog2(NB_ENTRIES + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [ID_WIDTH-1:0]       issue_id_i,
    input  logic [REG_W-1:0]          issue_rd_i,
    input  logic                      issue_we_i,
    input  logic [1:0][REG_W-1:0]     issue_rs_i,
    input  logic [1:0]                issue_rs_use_i,
    input  logic                      commit_valid_i,
    input  logic [ID_WIDTH-1:0]       commit_id_i,
    input  logic                      commit_kill_i,
    input  logic [ID_WIDTH-1:0]       ex_id_i,
    output logic                      ex_commit_o,
    input  logic                      retire_valid_i,
    input  logic [ID_WIDTH-1:0]       retire_id_i,
    output logic [CNT_W-1:0]          count_o
);

    logic [NB_ENTRIES-1:0] busy, we, lookup_hit, ex_hit, kill_hit, retire_hit, alloc;
    logic [REG_W-1:0]      rd [NB_ENTRIES];
    logic                  full, hazard, dup, handshake, same_cycle_kill, found;
    logic [CNT_W-1:0]      count_q, count_d;

    for (genvar g = 0; g < NB_ENTRIES; g++) begin : g_entry
        fir_xifu_sb_entry #(
            .ID_WIDTH (ID_WIDTH),
            .REG_W    (REG_W)
        ) u_entry (
            .clk          (clk_i),
            .rst_n        (rst_ni),
            .clear        (clear_i),
            .alloc        (alloc[g]),
            .alloc_id     (issue_id_i),
            .alloc_rd     (issue_rd_i),
            .alloc_we     (issue_we_i),
            .commit_valid (commit_valid_i),
            .commit_id    (commit_id_i),
            .commit_kill  (commit_kill_i),
            .retire_valid (retire_valid_i),
            .retire_id    (retire_id_i),
            .lookup_id    (issue_id_i),
            .ex_id        (ex_id_i),
            .busy         (busy[g]),
            .rd           (rd[g]),
            .we           (we[g]),
            .lookup_hit   (lookup_hit[g]),
            .ex_hit       (ex_hit[g]),
            .kill_hit     (kill_hit[g]),
            .retire_hit   (retire_hit[g])
        );
    end

    // gate uses registered slot state only, so a slot freed this cycle is usable next cycle
    always_comb begin
        full   = &busy;
        dup    = |lookup_hit;
        hazard = 1'b0;
        for (int i = 0; i < NB_ENTRIES; i++) begin
            if (we[i] && ((issue_rs_use_i[0] && (rd[i] == issue_rs_i[0])) ||
                          (issue_rs_use_i[1] && (rd[i] == issue_rs_i[1])) ||
                          (issue_we_i        && (rd[i] == issue_rd_i))))
                hazard = 1'b1;
        end
    end

    assign issue_ready_o   = !full && !hazard && !dup;
    assign handshake       = issue_valid_i && issue_ready_o && !clear_i;
    assign same_cycle_kill = commit_valid_i && commit_kill_i && (commit_id_i == issue_id_i);
    assign ex_commit_o     = |ex_hit;

    always_comb begin
        alloc = '0;
        found = 1'b0;
        for (int i = 0; i < NB_ENTRIES; i++) begin
            if (!busy[i] && !found) begin
                alloc[i] = handshake;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (handshake && !same_cycle_kill) count_d = count_d + CNT_W'(1);
        for (int i = 0; i < NB_ENTRIES; i++) begin
            if (kill_hit[i])   count_d = count_d - CNT_W'(1);
            if (retire_hit[i]) count_d = count_d - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      count_q <= '0;
        else if (clear_i) count_q <= '0;
        else              count_q <= count_d;
    end

    assign count_o = count_q;

    a_retire_committed: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (retire_valid_i && !clear_i) |-> (|retire_hit));
    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CNT_W'(NB_ENTRIES));

endmodule
